cxs_tx_credit_scheduler: RTL and testbench

Transmit-side scheduler for the CXS link layer. It sequences link activation and deactivation, and holds the transmit credit count granted by the receiver. It round-robin arbitrates those credits between NUM_REQ flit sources. During deactivation it returns every unused credit before the link is allowed to stop.

---
 rtl/cxs_tx_credit_scheduler_if.sv | 25 ++
 rtl/cxs_tx_credit_scheduler.sv | 112 +++++++++++
 tb/tb_cxs_tx_credit_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cxs_tx_credit_scheduler_if.sv
// rtl/cxs_tx_credit_scheduler_if.sv - link, credit and flit handshake bundle for the CXS tx scheduler
interface cxs_tx_credit_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic               link_en;
  logic               rx_active_ack;
  logic               crd_gnt;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               tx_active_req;
  logic               crd_rtn;
  logic [3:0]         credits;
  logic [1:0]         link_state;
  logic               crd_overflow;

  modport master (
    output link_en, rx_active_ack, crd_gnt, req,
    input  gnt, tx_active_req, crd_rtn, credits, link_state, crd_overflow
  );

  modport slave (
    input  link_en, rx_active_ack, crd_gnt, req,
    output gnt, tx_active_req, crd_rtn, credits, link_state, crd_overflow
  );
endinterface

// File: rtl/cxs_tx_credit_scheduler.sv
// rtl/cxs_tx_credit_scheduler.sv - CXS tx link sequencing, credit count and round-robin flit grant
module cxs_tx_credit_scheduler #(
  parameter int NUM_REQ = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  cxs_tx_credit_scheduler_if.slave    bus
);
  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ST_STOP       = 2'd0,
    ST_ACTIVATE   = 2'd1,
    ST_RUN        = 2'd2,
    ST_DEACTIVATE = 2'd3
  } state_t;

  state_t             state;
  logic [3:0]         credits;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      winner;
  logic [PW-1:0]      cand;
  logic [NUM_REQ-1:0] gnt_c;
  logic               tx_active_req;
  logic               crd_rtn;
  logic               crd_overflow;
  logic               rtn_now;
  logic               dec;
  logic               inc;

  // Scan offsets high to low so the nearest requester above rr_ptr is the last one written.
  always_comb begin
    gnt_c  = '0;
    winner = rr_ptr;
    cand   = rr_ptr;
    if (state == ST_RUN && credits != 4'd0 && |bus.req) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
        if (bus.req[cand]) winner = cand;
      end
      gnt_c[winner] = 1'b1;
    end
  end

  assign rtn_now = (state == ST_DEACTIVATE) && (credits != 4'd0);
  assign dec     = (|gnt_c) | rtn_now;
  assign inc     = bus.crd_gnt && (state != ST_STOP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_STOP;
      credits       <= 4'd0;
      rr_ptr        <= '0;
      tx_active_req <= 1'b0;
      crd_rtn       <= 1'b0;
      crd_overflow  <= 1'b0;
    end else begin
      crd_rtn <= rtn_now;

      if (|gnt_c) rr_ptr <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

      if (inc && !dec) begin
        if (credits == 4'd15) crd_overflow <= 1'b1;
        else                  credits      <= credits + 4'd1;
      end else if (dec && !inc) begin
        credits <= credits - 4'd1;
      end

      case (state)
        ST_STOP: begin
          if (bus.link_en) begin
            state         <= ST_ACTIVATE;
            tx_active_req <= 1'b1;
          end
        end
        ST_ACTIVATE: begin
          if (bus.rx_active_ack) begin
            state         <= ST_RUN;
            tx_active_req <= 1'b1;
          end else if (!bus.link_en) begin
            state         <= ST_STOP;
            tx_active_req <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!bus.link_en) begin
            state         <= ST_DEACTIVATE;
            tx_active_req <= 1'b0;
          end
        end
        ST_DEACTIVATE: begin
          // A late grant this cycle would leave a credit to return, so it blocks the stop.
          if (credits == 4'd0 && !bus.rx_active_ack && !bus.crd_gnt) begin
            state         <= ST_STOP;
            tx_active_req <= 1'b0;
          end
        end
        default: begin
          state         <= ST_STOP;
          tx_active_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt           = gnt_c;
  assign bus.tx_active_req = tx_active_req;
  assign bus.crd_rtn       = crd_rtn;
  assign bus.credits       = credits;
  assign bus.link_state    = state;
  assign bus.crd_overflow  = crd_overflow;
endmodule

// File: tb/tb_cxs_tx_credit_scheduler.sv
// tb/tb_cxs_tx_credit_scheduler.sv - self-checking bench for cxs_tx_credit_scheduler
module tb_cxs_tx_credit_scheduler;
  localparam int N = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cxs_tx_credit_scheduler_if #(.NUM_REQ(N)) bus();
  cxs_tx_credit_scheduler #(.NUM_REQ(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       le;
    logic       ack;
    logic       cg;
    logic [1:0] req;
    logic [1:0] gnt;
    int         st;
    int         cred;
    logic       tx;
    logic       rtn;
  } vec_t;
  vec_t tbl[19];

  // reference model: link state, credit count, next requester, sticky flag, registered outputs
  int ms, mc, mp, mo, mt, mr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic le, input logic ack, input logic cg, input logic [1:0] r);
    @(posedge clk);
    #1;
    bus.link_en       = le;
    bus.rx_active_ack = ack;
    bus.crd_gnt       = cg;
    bus.req           = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.link_en       = 1'b0;
    bus.rx_active_ack = 1'b0;
    bus.crd_gnt       = 1'b0;
    bus.req           = '0;
    resetn            = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    ms = 0; mc = 0; mp = 0; mo = 0; mt = 0; mr = 0;
  endtask

  task automatic bring_up(input int n);
    cyc(1'b1, 1'b0, 1'b0, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b1, 2'b00);
  endtask

  initial begin
    int rtn_cnt, first, last, zc, sc;
    logic le, ack, cg;
    logic [1:0] r;
    int eg, wk, take, add, ns;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1, 0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'b11, 2'b00, 2, 0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2, 1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2, 2, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2, 3, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 2, 4, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'b11, 2'b10, 2, 3, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 2, 2, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'b11, 2'b10, 2, 1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 2, 0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 2, 0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2, 0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2, 1, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2, 2, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 2, 3, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2, 3, 1'b1, 1'b0};

    do_reset();
    chk("reset_overflow", int'(bus.crd_overflow), 0);

    // bring-up, round-robin and simultaneous grant/credit vectors
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].le, tbl[i].ack, tbl[i].cg, tbl[i].req);
      chk($sformatf("tbl%0d_gnt", i),     int'(bus.gnt),           int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_state", i),   int'(bus.link_state),    tbl[i].st);
      chk($sformatf("tbl%0d_credits", i), int'(bus.credits),       tbl[i].cred);
      chk($sformatf("tbl%0d_txreq", i),   int'(bus.tx_active_req), int'(tbl[i].tx));
      chk($sformatf("tbl%0d_crdrtn", i),  int'(bus.crd_rtn),       int'(tbl[i].rtn));
    end

    // saturation
    do_reset();
    bring_up(0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 2'b00);
      chk($sformatf("sat_credits_%0d", k), int'(bus.credits), k);
      chk($sformatf("sat_ovf_%0d", k), int'(bus.crd_overflow), 0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 2'b00);
      chk("sat_credits_hold", int'(bus.credits), 15);
      chk("sat_ovf_sticky", int'(bus.crd_overflow), 1);
    end

    // teardown with 5 credits
    do_reset();
    chk("ovf_cleared_by_reset", int'(bus.crd_overflow), 0);
    bring_up(5);
    cyc(1'b0, 1'b1, 1'b0, 2'b00);
    chk("td_state_run", int'(bus.link_state), 2);
    chk("td_credits_5", int'(bus.credits), 5);
    rtn_cnt = 0; first = -1; last = -1; zc = -1; sc = -1;
    for (int t = 0; t < 10; t++) begin
      cyc(1'b0, (t == 0), 1'b0, 2'b11);
      chk("td_gnt_zero", int'(bus.gnt), 0);
      if (bus.crd_rtn) begin
        rtn_cnt++;
        if (first < 0) first = t;
        last = t;
      end
      if (bus.credits == 4'd0 && zc < 0) zc = t;
      if (bus.link_state == 2'd0 && sc < 0) sc = t;
    end
    chk("td_rtn_count", rtn_cnt, 5);
    chk("td_rtn_consecutive", last - first + 1, 5);
    chk("td_credits_zero_cycle", zc, 5);
    chk("td_stop_after_zero", sc, zc + 1);

    // asynchronous reset while granting
    do_reset();
    bring_up(7);
    cyc(1'b1, 1'b1, 1'b0, 2'b11);
    chk("rst_pre_gnt", int'(bus.gnt), 1);
    chk("rst_pre_credits", int'(bus.credits), 7);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_state", int'(bus.link_state), 0);
    chk("rst_credits", int'(bus.credits), 0);
    chk("rst_txreq", int'(bus.tx_active_req), 0);
    chk("rst_crdrtn", int'(bus.crd_rtn), 0);
    chk("rst_ovf", int'(bus.crd_overflow), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_crdrtn", int'(bus.crd_rtn), 0);
    chk("rst_hold_credits", int'(bus.credits), 0);

    // random traffic against the reference model
    do_reset();
    le = 1'b0;
    ack = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) le = ~le;
      if ($urandom_range(0, 5) == 0) ack = ~ack;
      cg = ($urandom_range(0, 9) < 6);
      r  = 2'($urandom_range(0, 3));
      cyc(le, ack, cg, r);

      eg = 0;
      wk = -1;
      if (ms == 2 && mc > 0) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (mp + i) % N;
          if (wk < 0 && r[k]) wk = k;
        end
        if (wk >= 0) eg = 1 << wk;
      end
      chk("rnd_gnt",     int'(bus.gnt),           eg);
      chk("rnd_state",   int'(bus.link_state),    ms);
      chk("rnd_credits", int'(bus.credits),       mc);
      chk("rnd_txreq",   int'(bus.tx_active_req), mt);
      chk("rnd_crdrtn",  int'(bus.crd_rtn),       mr);
      chk("rnd_ovf",     int'(bus.crd_overflow),  mo);

      mr   = (ms == 3 && mc > 0) ? 1 : 0;
      take = (eg != 0 || mr == 1) ? 1 : 0;
      add  = (cg && ms != 0) ? 1 : 0;
      ns = ms;
      case (ms)
        0: if (le) ns = 1;
        1: if (ack) ns = 2; else if (!le) ns = 0;
        2: if (!le) ns = 3;
        default: if (mc == 0 && !ack && !cg) ns = 0;
      endcase
      mc = mc + add - take;
      if (mc > 15) begin
        mc = 15;
        mo = 1;
      end
      if (wk >= 0) mp = (wk + 1) % N;
      ms = ns;
      mt = (ms == 1 || ms == 2) ? 1 : 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
